// File: rtl/srl_len_sequencer_pkg.sv
// Shared types and sizing helpers for the delay-line length sequencer.
package srl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SWITCH = 2'd1,
        FLUSH  = 2'd2
    } srl_state_t;

    localparam int LEN_W = 32;

    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/srl_len_sequencer_if.sv
// Bus bundle between the sequencer and its environment (upstream source and delay line).
interface srl_len_sequencer_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 130
);
    import srl_pkg::*;

    logic                          in_valid;
    logic [WIDTH-1:0]              in_data;
    logic                          flush;
    logic                          len_req_valid;
    logic [LEN_W-1:0]              len_req;
    logic                          len_req_ready;
    logic                          len_err;
    logic [WIDTH-1:0]              sr_i;
    logic [LEN_W-1:0]              sr_l;
    logic                          sr_r;
    logic                          out_valid;
    logic [fill_w(DEPTH)-1:0]      fill_level;

    modport master (
        output in_valid, in_data, flush, len_req_valid, len_req,
        input  len_req_ready, len_err, sr_i, sr_l, sr_r, out_valid, fill_level
    );

    modport slave (
        input  in_valid, in_data, flush, len_req_valid, len_req,
        output len_req_ready, len_err, sr_i, sr_l, sr_r, out_valid, fill_level
    );

endinterface

// File: rtl/srl_len_sequencer_valid_shadow.sv
// Shadow valid-bit line tracking which delay-line positions hold real samples, plus occupancy count.
module srl_valid_shadow
    import srl_pkg::*;
#(
    parameter  int DEPTH  = 130,
    localparam int TAP_W  = $clog2(DEPTH),
    localparam int FILL_W = fill_w(DEPTH)
) (
    input  logic              clk,
    input  logic              r,
    input  logic              clr,
    input  logic              push,
    input  logic [TAP_W-1:0]  tap,
    output logic              tap_bit,
    output logic [FILL_W-1:0] fill_level
);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);

    logic [DEPTH-1:0]  vbits_q, vbits_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              drop_s;

    assign drop_s     = vbits_q[DEPTH-1];
    assign tap_bit    = vbits_q[tap];
    assign fill_level = fill_q;

    // Next shadow contents and occupancy; a push and a drop in the same cycle cancel out.
    always_comb begin
        vbits_d = {vbits_q[DEPTH-2:0], push};
        fill_d  = fill_q;
        if (clr) begin
            vbits_d = {DEPTH{1'b0}};
            fill_d  = FILL_ZERO;
        end else if (push && !drop_s) begin
            fill_d = (fill_q == FILL_MAX) ? fill_q : (fill_q + FILL_ONE);
        end else if (!push && drop_s) begin
            fill_d = (fill_q == FILL_ZERO) ? fill_q : (fill_q - FILL_ONE);
        end else begin
            fill_d = fill_q;
        end
    end

    // Shadow state registers.
    always_ff @(posedge clk) begin
        if (r) begin
            vbits_q <= {DEPTH{1'b0}};
            fill_q  <= FILL_ZERO;
        end else begin
            vbits_q <= vbits_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/srl_len_sequencer.sv
// Upstream controller for a variable-length resettable delay line: length handshake, flush, valid shadow.
// Optional SRL_LEN_CLAMP_EN: out-of-range length requests are clamped to DEPTH-1 instead of ignored.
module srl_len_sequencer
    import srl_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 130,
    parameter int INIT_LEN = 129
) (
    input  logic                clk,
    input  logic                r,
    srl_len_sequencer_if.slave  bus
);

    localparam int TAP_W  = $clog2(DEPTH);
    localparam int FILL_W = fill_w(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] INIT_L  = LEN_W'(INIT_LEN);
`ifdef SRL_LEN_CLAMP_EN
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(DEPTH - 1);
`endif

    srl_state_t        state_q, state_d;
    logic [WIDTH-1:0]  sr_i_q, sr_i_d;
    logic [LEN_W-1:0]  sr_l_q, sr_l_d;
    logic              sr_r_q, sr_r_d;
    logic              len_err_q, len_err_d;
    logic              flush_go_s;
    logic              legal_s;
    logic              push_s;
    logic              tap_bit_s;
    logic [FILL_W-1:0] fill_s;

    assign legal_s = (bus.len_req < DEPTH_L);
    // The FLUSH-cycle sample is dropped because the line is held in reset while it arrives.
    assign push_s  = bus.in_valid && (state_q != FLUSH);

    // Next-state, length load and delay-line drive decisions.
    always_comb begin
        state_d    = state_q;
        sr_i_d     = bus.in_valid ? bus.in_data : {WIDTH{1'b0}};
        sr_l_d     = sr_l_q;
        sr_r_d     = 1'b0;
        len_err_d  = 1'b0;
        flush_go_s = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    state_d    = FLUSH;
                    sr_r_d     = 1'b1;
                    flush_go_s = 1'b1;
                end else if (bus.len_req_valid) begin
                    if (legal_s) begin
                        sr_l_d  = bus.len_req;
                        state_d = SWITCH;
                    end else begin
                        len_err_d = 1'b1;
`ifdef SRL_LEN_CLAMP_EN
                        sr_l_d    = MAX_L;
                        state_d   = SWITCH;
`else
                        state_d   = RUN;
`endif
                    end
                end else begin
                    state_d = RUN;
                end
            end
            SWITCH:  state_d = RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Control FSM and delay-line output registers.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q   <= RUN;
            sr_i_q    <= {WIDTH{1'b0}};
            sr_l_q    <= INIT_L;
            sr_r_q    <= 1'b1;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_i_q    <= sr_i_d;
            sr_l_q    <= sr_l_d;
            sr_r_q    <= sr_r_d;
            len_err_q <= len_err_d;
        end
    end

    srl_valid_shadow #(.DEPTH(DEPTH)) u_shadow (
        .clk        (clk),
        .r          (r),
        .clr        (flush_go_s),
        .push       (push_s),
        .tap        (sr_l_q[TAP_W-1:0]),
        .tap_bit    (tap_bit_s),
        .fill_level (fill_s)
    );

    // A same-cycle flush takes precedence, so the request is held off rather than lost.
    assign bus.len_req_ready = (state_q == RUN) && !bus.flush;
    assign bus.len_err       = len_err_q;
    assign bus.sr_i          = sr_i_q;
    assign bus.sr_l          = sr_l_q;
    assign bus.sr_r          = sr_r_q;
    assign bus.out_valid     = tap_bit_s && (state_q != SWITCH) && !sr_r_q;
    assign bus.fill_level    = fill_s;

endmodule
